// File: rtl/match_judge.sv
// match_judge: collects GROUP card selections, judges whether their symbols
// match, keeps the score and sequences per-card redraw requests to the
// drawing engine over a req/ack handshake.
module match_judge #(
   parameter int unsigned NUM_CARDS = 9,
   parameter int unsigned SYM_W     = 2,
   parameter int unsigned GROUP     = 3,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned SCORE_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_CARDS*SYM_W-1:0] symbols,
   input  logic [IDX_W-1:0]           sel_idx,
   input  logic                       sel_valid,
   output logic                       sel_ready,
   output logic                       sel_err,
   output logic [NUM_CARDS-1:0]       picked,
   output logic [NUM_CARDS-1:0]       removed,
   output logic                       result_valid,
   output logic                       result_match,
   output logic                       draw_req,
   output logic [IDX_W-1:0]           draw_idx,
   output logic                       draw_mode,
   input  logic                       draw_ack,
   output logic [SCORE_W-1:0]         score,
   output logic                       all_done
);

   localparam int unsigned CNT_W  = $clog2(GROUP + 1);
   localparam int unsigned SLOT_W = $clog2(GROUP);
   localparam int unsigned PC_W   = $clog2(NUM_CARDS + 1);

   typedef enum logic [2:0] {
      S_COLLECT = 3'd0,
      S_COMPARE = 3'd1,
      S_DRAW    = 3'd2,
      S_GAP     = 3'd3,
      S_CHECK   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [CNT_W-1:0]     r_count;
   logic [SLOT_W-1:0]    r_slot;
   logic [IDX_W-1:0]     r_slot_idx [GROUP];
   logic [SYM_W-1:0]     r_slot_sym [GROUP];
   logic [NUM_CARDS-1:0] r_picked;
   logic [NUM_CARDS-1:0] r_removed;
   logic [SCORE_W-1:0]   r_score;
   logic                 r_sel_err;
   logic                 r_result_valid;
   logic                 r_result_match;
   logic                 r_draw_req;
   logic [IDX_W-1:0]     r_draw_idx;
   logic                 r_draw_mode;
   logic                 r_all_done;

   logic [NUM_CARDS-1:0] w_onehot;
   logic                 w_reject;
   logic                 w_last;
   logic [SYM_W-1:0]     w_sel_sym;
   logic                 w_match;
   logic                 w_slot_last;
   logic [SLOT_W-1:0]    w_slot_nxt;
   logic [IDX_W-1:0]     w_nxt_idx;
   logic [NUM_CARDS-1:0] w_removed_nxt;
   logic [PC_W-1:0]      w_pop;
   logic                 w_game_over;

   // Selection qualification, symbol lookup, match and end-of-game decode
   always_comb begin
      w_onehot  = NUM_CARDS'(1) << sel_idx;
      w_reject  = (32'(sel_idx) >= NUM_CARDS) || (|(w_onehot & (r_removed | r_picked)));
      w_last    = (r_count == CNT_W'(GROUP - 1));
      w_sel_sym = '0;
      for (int i = 0; i < int'(NUM_CARDS); i++) begin
         if (sel_idx == IDX_W'(i)) w_sel_sym = symbols[i*SYM_W +: SYM_W];
      end
      w_match = 1'b1;
      for (int s = 1; s < int'(GROUP); s++) begin
         if (r_slot_sym[s] != r_slot_sym[0]) w_match = 1'b0;
      end
      w_slot_last = (r_slot == SLOT_W'(GROUP - 1));
      w_slot_nxt  = r_slot + SLOT_W'(1);
      w_nxt_idx   = '0;
      for (int s = 0; s < int'(GROUP); s++) begin
         if (w_slot_nxt == SLOT_W'(s)) w_nxt_idx = r_slot_idx[s];
      end
      w_removed_nxt = r_result_match ? (r_removed | r_picked) : r_removed;
      w_pop = '0;
      for (int i = 0; i < int'(NUM_CARDS); i++) begin
         w_pop = w_pop + PC_W'(w_removed_nxt[i]);
      end
      // Fewer than GROUP cards left means no further attempt is possible
      w_game_over = (w_pop > PC_W'(NUM_CARDS - GROUP));
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_COLLECT;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: if (sel_valid && !w_reject && w_last) w_state_nxt = S_COMPARE;
         S_COMPARE: w_state_nxt = S_DRAW;
         S_DRAW:    if (draw_ack) w_state_nxt = w_slot_last ? S_CHECK : S_GAP;
         S_GAP:     w_state_nxt = S_DRAW;
         S_CHECK:   w_state_nxt = w_game_over ? S_DONE : S_COLLECT;
         S_DONE:    w_state_nxt = S_DONE;
         default:   w_state_nxt = S_COLLECT;
      endcase
   end

   // Output decode: ready is the only combinational output
   always_comb begin
      sel_ready    = (r_state == S_COLLECT);
      sel_err      = r_sel_err;
      picked       = r_picked;
      removed      = r_removed;
      result_valid = r_result_valid;
      result_match = r_result_match;
      draw_req     = r_draw_req;
      draw_idx     = r_draw_idx;
      draw_mode    = r_draw_mode;
      score        = r_score;
      all_done     = r_all_done;
   end

   // Datapath and registered outputs, updated per state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count        <= '0;
         r_slot         <= '0;
         for (int s = 0; s < int'(GROUP); s++) begin
            r_slot_idx[s] <= '0;
            r_slot_sym[s] <= '0;
         end
         r_picked       <= '0;
         r_removed      <= '0;
         r_score        <= '0;
         r_sel_err      <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_match <= 1'b0;
         r_draw_req     <= 1'b0;
         r_draw_idx     <= '0;
         r_draw_mode    <= 1'b0;
         r_all_done     <= 1'b0;
      end else begin
         r_sel_err      <= 1'b0;
         r_result_valid <= 1'b0;
         case (r_state)
            S_COLLECT: begin
               if (sel_valid) begin
                  if (w_reject) begin
                     r_sel_err <= 1'b1;
                  end else begin
                     for (int s = 0; s < int'(GROUP); s++) begin
                        if (r_count == CNT_W'(s)) begin
                           r_slot_idx[s] <= sel_idx;
                           r_slot_sym[s] <= w_sel_sym;
                        end
                     end
                     r_picked <= r_picked | w_onehot;
                     r_count  <= r_count + CNT_W'(1);
                  end
               end
            end
            S_COMPARE: begin
               r_result_valid <= 1'b1;
               r_result_match <= w_match;
               if (w_match && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
               r_slot      <= '0;
               r_draw_idx  <= r_slot_idx[0];
               r_draw_mode <= w_match;
               r_draw_req  <= 1'b1;
            end
            S_DRAW: begin
               if (draw_ack) r_draw_req <= 1'b0;
            end
            S_GAP: begin
               r_slot     <= w_slot_nxt;
               r_draw_idx <= w_nxt_idx;
               r_draw_req <= 1'b1;
            end
            S_CHECK: begin
               r_removed <= w_removed_nxt;
               r_picked  <= '0;
               r_count   <= '0;
               if (w_game_over) r_all_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: a scoreboard of expected judgements, redraw requests
// and selection errors is filled by the stimulus and drained by a monitor.
module tb_match_judge;

   localparam int unsigned K_RES = 0;
   localparam int unsigned K_DRW = 1;
   localparam int unsigned K_ERR = 2;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] idx;
      logic       mode;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   // default configuration
   logic [17:0] symbols;
   logic [3:0]  sel_idx = '0;
   logic        sel_valid = 1'b0;
   logic        sel_ready, sel_err, result_valid, result_match;
   logic [8:0]  picked, removed;
   logic        draw_req, draw_mode, all_done;
   logic [3:0]  draw_idx;
   logic        draw_ack = 1'b0;
   logic [7:0]  score;

   // five cards, pairs
   logic [9:0]  symbols_b;
   logic [2:0]  sel_idx_b = '0;
   logic        sel_valid_b = 1'b0;
   logic        sel_ready_b, sel_err_b, result_valid_b, result_match_b;
   logic [4:0]  picked_b, removed_b;
   logic        draw_req_b, draw_mode_b, all_done_b;
   logic [2:0]  draw_idx_b;
   logic        draw_ack_b = 1'b1;
   logic [7:0]  score_b;

   ev_t         exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          ack_mode = 0;
   int          ack_lat = 2;
   int          ack_cnt = 0;

   always #5 clk = ~clk;

   match_judge dut (
      .clk(clk), .reset_n(reset_n), .symbols(symbols), .sel_idx(sel_idx),
      .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
      .picked(picked), .removed(removed), .result_valid(result_valid),
      .result_match(result_match), .draw_req(draw_req), .draw_idx(draw_idx),
      .draw_mode(draw_mode), .draw_ack(draw_ack), .score(score), .all_done(all_done)
   );

   match_judge #(.NUM_CARDS(5), .SYM_W(2), .GROUP(2), .IDX_W(3), .SCORE_W(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .symbols(symbols_b), .sel_idx(sel_idx_b),
      .sel_valid(sel_valid_b), .sel_ready(sel_ready_b), .sel_err(sel_err_b),
      .picked(picked_b), .removed(removed_b), .result_valid(result_valid_b),
      .result_match(result_match_b), .draw_req(draw_req_b), .draw_idx(draw_idx_b),
      .draw_mode(draw_mode_b), .draw_ack(draw_ack_b), .score(score_b), .all_done(all_done_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   task automatic push(input int unsigned kind, input int unsigned idx, input logic mode);
      ev_t e;
      e.kind = 2'(kind);
      e.idx  = 4'(idx);
      e.mode = mode;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input ev_t got);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d idx %0d mode %0d, expected none",
                  got.kind, got.idx, got.mode);
      end else begin
         e = exp_q.pop_front();
         if (e !== got) begin
            n_fail++;
            $display("FAIL event: got kind %0d idx %0d mode %0d, expected kind %0d idx %0d mode %0d",
                     got.kind, got.idx, got.mode, e.kind, e.idx, e.mode);
         end
      end
   endtask

   // Monitor: every DUT output event is checked against the scoreboard
   task automatic monitor();
      logic       prev_req = 1'b0;
      logic [3:0] held_idx = '0;
      logic       held_mode = 1'b0;
      ev_t        g;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_req = 1'b0;
         end else begin
            if (result_valid) begin
               g.kind = 2'(K_RES); g.idx = '0; g.mode = result_match;
               pop_cmp(g);
            end
            if (sel_err) begin
               g.kind = 2'(K_ERR); g.idx = '0; g.mode = 1'b0;
               pop_cmp(g);
            end
            if (draw_req && !prev_req) begin
               g.kind = 2'(K_DRW); g.idx = draw_idx; g.mode = draw_mode;
               pop_cmp(g);
               held_idx  = draw_idx;
               held_mode = draw_mode;
            end else if (draw_req) begin
               chk("draw_stable", {draw_idx, draw_mode}, {held_idx, held_mode});
            end
            prev_req = draw_req;
         end
      end
   endtask

   // Drawing-engine model: 0 = ack after ack_lat cycles, 1 = always high, 2 = never
   task automatic ack_driver();
      forever begin
         @(negedge clk);
         case (ack_mode)
            1: draw_ack = 1'b1;
            2: draw_ack = 1'b0;
            default: begin
               if (draw_ack) begin
                  draw_ack = 1'b0;
                  ack_cnt  = 0;
               end else if (draw_req) begin
                  if (ack_cnt >= ack_lat) draw_ack = 1'b1;
                  else ack_cnt++;
               end
            end
         endcase
      end
   endtask

   task automatic strobe(input int unsigned idx);
      @(negedge clk);
      sel_idx   = 4'(idx);
      sel_valid = 1'b1;
      @(negedge clk);
      sel_valid = 1'b0;
   endtask

   task automatic strobe_b(input int unsigned idx);
      @(negedge clk);
      sel_idx_b   = 3'(idx);
      sel_valid_b = 1'b1;
      @(negedge clk);
      sel_valid_b = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!sel_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(sel_ready), 32'd1);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!all_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(all_done), 32'd1);
   endtask

   initial begin
      // card i symbol at [2i+:2]; cards {0,1,4}=0, {3,5,7}=1, {2,6,8}=2
      symbols   = {2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
      symbols_b = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
      fork
         monitor();
         ack_driver();
      join_none

      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(sel_ready), 32'd1);
      chk("reset_outs", {picked, removed, score, draw_req, all_done, result_match},
          32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // matching group 0,1,4 with two-cycle ack latency
      ack_mode = 0;
      push(K_RES, 0, 1'b1);
      push(K_DRW, 0, 1'b1); push(K_DRW, 1, 1'b1); push(K_DRW, 4, 1'b1);
      strobe(0); strobe(1); strobe(4);
      chk("compare_state", 32'(sel_ready), 32'd0);
      @(negedge clk);
      chk("latency_rv", {31'd0, result_valid}, 32'd1);
      wait_ready("wait_ready_1");
      chk("score_1", 32'(score), 32'd1);
      chk("removed_1", 32'(removed), 32'h013);
      chk("picked_1", 32'(picked), 32'h000);

      // mismatching group 2,3,5
      push(K_RES, 0, 1'b0);
      push(K_DRW, 2, 1'b0); push(K_DRW, 3, 1'b0); push(K_DRW, 5, 1'b0);
      strobe(2); strobe(3); strobe(5);
      wait_ready("wait_ready_2");
      chk("score_mis", 32'(score), 32'd1);
      chk("removed_mis", 32'(removed), 32'h013);
      chk("result_hold", 32'(result_match), 32'd0);

      // rejected selections
      push(K_ERR, 0, 1'b0);
      strobe(0);
      chk("picked_rej_removed", 32'(picked), 32'h000);
      strobe(3);
      push(K_ERR, 0, 1'b0);
      strobe(3);
      chk("picked_dup", 32'(picked), 32'h008);
      push(K_ERR, 0, 1'b0);
      strobe(9);
      chk("picked_range", 32'(picked), 32'h008);

      // complete 3,5,7 and strobe during the redraw sequence
      push(K_RES, 0, 1'b1);
      push(K_DRW, 3, 1'b1); push(K_DRW, 5, 1'b1); push(K_DRW, 7, 1'b1);
      strobe(5); strobe(7);
      strobe(2); strobe(6);
      wait_ready("wait_ready_3");
      chk("score_2", 32'(score), 32'd2);
      chk("removed_2", 32'(removed), 32'h0BB);
      chk("picked_ignored", 32'(picked), 32'h000);
      chk("not_done_yet", 32'(all_done), 32'd0);

      // final group with ack held high (ack coincides with request rise)
      ack_mode = 1;
      push(K_RES, 0, 1'b1);
      push(K_DRW, 2, 1'b1); push(K_DRW, 6, 1'b1); push(K_DRW, 8, 1'b1);
      strobe(2); strobe(6); strobe(8);
      wait_done("wait_done");
      chk("score_3", 32'(score), 32'd3);
      chk("removed_all", 32'(removed), 32'h1FF);
      chk("done_ready", 32'(sel_ready), 32'd0);
      strobe(0);
      repeat (2) @(negedge clk);
      chk("done_ignored", {picked, draw_req, all_done}, 32'd1);

      // asynchronous reset in the middle of a stalled handshake
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      ack_mode = 2;
      push(K_RES, 0, 1'b1);
      push(K_DRW, 0, 1'b1);
      strobe(0); strobe(1); strobe(4);
      begin
         int n = 0;
         while (!draw_req && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("stall_req", {draw_req, score, picked}, {1'b1, 8'd1, 9'h013});
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_outs", {draw_req, picked, score, removed, all_done}, 32'd0);
      chk("async_rst_ready", 32'(sel_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      ack_mode = 0;
      push(K_RES, 0, 1'b1);
      push(K_DRW, 3, 1'b1); push(K_DRW, 5, 1'b1); push(K_DRW, 7, 1'b1);
      strobe(3); strobe(5); strobe(7);
      repeat (2) @(negedge clk);
      wait_ready("wait_ready_4");
      chk("score_after_rst", 32'(score), 32'd1);
      chk("removed_after_rst", 32'(removed), 32'h0A8);

      // five cards, pairs: game ends with card 4 left
      strobe_b(0); strobe_b(1);
      repeat (8) @(negedge clk);
      chk("b_first", {score_b, removed_b, all_done_b, sel_ready_b}, {8'd1, 5'h03, 1'b0, 1'b1});
      strobe_b(2); strobe_b(3);
      begin
         int n = 0;
         while (!all_done_b && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("b_done", {score_b, removed_b, all_done_b, sel_ready_b, result_match_b},
          {8'd2, 5'h0F, 1'b1, 1'b0, 1'b1});

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/match_judge.md
Name: match_judge

Overview:
- Parametrised selection and match-evaluation engine for the card-matching game.
- Collects GROUP player selections out of NUM_CARDS face-down cards and compares their symbols, then keeps score.
- Sequences per-card redraw requests (erase on match, restore on mismatch) to the VGA drawing engine through a req/ack handshake.
- Flags game completion. Sits between the debounced switch/key front end and the drawing datapath.

Parameters:
- NUM_CARDS, 9, number of cards on the board (2..15).
- SYM_W, 2, bits per card symbol.
- GROUP, 3, cards per match attempt (2..NUM_CARDS).
- IDX_W, 4, card index width; must satisfy 2**IDX_W >= NUM_CARDS.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- symbols  in  NUM_CARDS*SYM_W  card i symbol at [i*SYM_W +: SYM_W]; static during a game.
- sel_idx  in  IDX_W  0-based card index being selected.
- sel_valid  in  1  one-cycle selection strobe; already edge-detected upstream.
- sel_ready  out  1  high only in COLLECT.
- sel_err  out  1  one-cycle pulse when a strobed selection is rejected.
- picked  out  NUM_CARDS  cards selected in the current attempt.
- removed  out  NUM_CARDS  cards already matched and erased.
- result_valid  out  1  one-cycle pulse when an attempt is judged.
- result_match  out  1  judgement; valid with result_valid, held until the next judgement.
- draw_req  out  1  redraw request.
- draw_idx  out  IDX_W  card to redraw; stable while draw_req is high.
- draw_mode  out  1  1 = erase card, 0 = restore face-down card; stable while draw_req is high.
- draw_ack  in  1  drawing engine finished the current request.
- score  out  SCORE_W  matched groups, saturating.
- all_done  out  1  game over; sticky until reset.

Behaviour:
- Reset (async, any state including mid-handshake):
  - State goes to COLLECT, so sel_ready=1.
  - All other outputs go to 0 immediately: picked, removed, score, draw_req, draw_idx, draw_mode, result_valid, result_match, sel_err, all_done.
  - Slot count and the slot idx/symbol stores clear.
- States:
  - COLLECT, COMPARE, DRAW, GAP, CHECK, DONE.
  - Registered state machine; all outputs registered except sel_ready, which is decoded from state.
- COLLECT:
  - On sel_valid, reject (sel_err=1 next cycle, nothing else changes) if sel_idx >= NUM_CARDS, removed[sel_idx]=1, or picked[sel_idx]=1.
  - Otherwise accept: store idx and that card's symbol into slot[count], set picked[sel_idx], and increment count.
  - Acceptance that brings count to GROUP moves to COMPARE at the same edge.
- sel_valid outside COLLECT: ignored, no sel_err.
- COMPARE (1 cycle):
  - match = all GROUP stored symbols equal.
  - At the exit edge: result_valid=1 for one cycle and result_match=match.
  - If match, score = score+1, saturating at all-ones.
  - Load slot 0, assert draw_req with draw_mode=match, go to DRAW.
  - Latency: last accepted sel_valid edge to result_valid high = 2 edges.
- DRAW:
  - Hold draw_req/draw_idx/draw_mode until draw_ack is sampled high.
  - On ack, draw_req drops next cycle.
  - If more slots remain, go to GAP; otherwise go to CHECK.
  - draw_ack outside DRAW is ignored.
- GAP (1 cycle): draw_req=0, advance slot, reassert draw_req for the next slot, return to DRAW. So back-to-back requests always have at least one low cycle between them.
- CHECK (1 cycle):
  - If the attempt matched, removed |= picked.
  - Clear picked and count.
  - If (NUM_CARDS − popcount(removed after update)) < GROUP, go to DONE; otherwise go to COLLECT.
- DONE: all_done=1, sel_ready=0, no requests; leaves only on reset.
- Boundary conditions:
  - NUM_CARDS not a multiple of GROUP: the game ends with fewer than GROUP cards left.
  - A mismatch never changes removed or score.
  - draw_ack high in the same cycle draw_req first rises is a valid acknowledge.
  - Score saturation holds at max; result_valid still pulses.

Test Plan:
- Defaults. Symbols: cards {0,1,4}=0, {3,5,7}=1, {2,6,8}=2. Select 0,1,4 -> result_valid and result_match=1 two edges after the third strobe. Then three erase requests for idx 0,1,4 with draw_mode=1 and ≥1 low cycle between requests. score=1, removed=9'h013, picked=0.
- Select 2,3,5 -> result_match=0. Restore requests for idx 2,3,5 with draw_mode=0. score and removed unchanged, back in COLLECT.
- After the first scenario: strobe idx 0 (removed) -> sel_err pulse. Strobe 3, then 3 again -> sel_err on the second strobe and picked=9'h008. Strobe idx 9 -> sel_err. Strobes during DRAW -> no sel_err, ignored.
- Play all three matching groups -> score=3, removed=9'h1FF, all_done=1 after the final CHECK, sel_ready=0, further strobes ignored.
- NUM_CARDS=5, GROUP=2, symbols {0,0,1,1,2}. Match {0,1} and {2,3} -> all_done=1 with card 4 remaining.
- Assert reset_n low while draw_req is high, with draw_ack never given -> draw_req, picked, score, removed and all_done drop asynchronously. After release, sel_ready=1 and a new game plays normally.
